// File: rtl/uart_word_rx.sv
`timescale 1ns/1ps
// uart_word_rx: receives 4-byte words as serial frames (start, 8 data LSB first,
// parity, stop) with one rx sample per clock. It reports the word and per-byte
// parity errors on rx_done, and flags bad stop bits or an overlong inter-byte gap
// on framing_error.
module uart_word_rx #(
  parameter bit PARITY_ODD = 1'b0,
  parameter int GAP_LIMIT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] dat_out,
  output logic        rx_done,
  output logic [3:0]  parity_error,
  output logic        framing_error,
  output logic        busy
);

  localparam int GW = (GAP_LIMIT > 1) ? $clog2(GAP_LIMIT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP,
    ST_BREAK
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_bit_cnt;
  logic [1:0]  r_byte_idx;
  logic [GW-1:0] r_gap_cnt;
  logic [7:0]  r_shift;
  logic [31:0] r_word;
  logic [3:0]  r_par_shadow;
  logic [31:0] r_dat_out;
  logic [3:0]  r_parity_error;
  logic        r_rx_done;
  logic        r_framing_error;

  logic        w_word_done;
  logic        w_frame_err;
  logic        w_par_bad;
  logic [3:0]  w_lane_we;

  // A byte's parity is judged while its parity bit is on the line.
  assign w_par_bad = (^r_shift) ^ rx ^ PARITY_ODD;

  // One write strobe per byte lane of the assembled word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane_we[gi] = (r_state == ST_PARITY) && (r_byte_idx == 2'(gi));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and completion / error strobes.
  always_comb begin
    w_state_next = r_state;
    w_word_done  = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rx) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
      end
      ST_PARITY: begin
        w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (rx) begin
          if (r_byte_idx == 2'd3) begin
            w_state_next = ST_IDLE;
            w_word_done  = 1'b1;
          end else begin
            w_state_next = ST_GAP;
          end
        end else begin
          // A low stop bit means the line is broken; wait for it to go idle.
          w_state_next = ST_BREAK;
          w_frame_err  = 1'b1;
        end
      end
      ST_GAP: begin
        if (!rx) begin
          w_state_next = ST_DATA;
        end else if (r_gap_cnt == GW'(GAP_LIMIT - 1)) begin
          w_state_next = ST_IDLE;
          w_frame_err  = 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: bit shifting, byte/gap counting, word assembly and output latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt       <= '0;
      r_byte_idx      <= '0;
      r_gap_cnt       <= '0;
      r_shift         <= '0;
      r_word          <= '0;
      r_par_shadow    <= '0;
      r_dat_out       <= '0;
      r_parity_error  <= '0;
      r_rx_done       <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_rx_done       <= w_word_done;
      r_framing_error <= w_frame_err;
      case (r_state)
        ST_IDLE, ST_BREAK: begin
          // Any partial word is forgotten here; the next start begins at byte 0.
          r_bit_cnt    <= '0;
          r_byte_idx   <= '0;
          r_gap_cnt    <= '0;
          r_par_shadow <= '0;
        end
        ST_DATA: begin
          r_shift   <= {rx, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_gap_cnt <= '0;
        end
        ST_PARITY: begin
          for (int i = 0; i < 4; i++) begin
            if (w_lane_we[i]) begin
              r_word[i*8 +: 8] <= r_shift;
              r_par_shadow[i]  <= w_par_bad;
            end
          end
        end
        ST_STOP: begin
          r_gap_cnt <= '0;
          if (rx && (r_byte_idx != 2'd3)) r_byte_idx <= r_byte_idx + 2'd1;
          if (w_word_done) begin
            r_dat_out      <= r_word;
            r_parity_error <= r_par_shadow;
          end
        end
        ST_GAP: begin
          if (rx) r_gap_cnt <= r_gap_cnt + GW'(1);
          else    r_gap_cnt <= '0;
        end
        default: begin
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign dat_out       = r_dat_out;
  assign parity_error  = r_parity_error;
  assign rx_done       = r_rx_done;
  assign framing_error = r_framing_error;
  assign busy          = (r_state != ST_IDLE) && (r_state != ST_BREAK);

endmodule

// File: tb/tb_uart_word_rx.sv
`timescale 1ns/1ps
// Testbench for uart_word_rx: an even-parity and an odd-parity instance share the
// clock and reset; a bench transmitter drives one of them while the other idles.
module tb_uart_word_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rx_e, rx_o;
  logic [31:0] dat_e, dat_o;
  logic        done_e, done_o, fe_e, fe_o, busy_e, busy_o;
  logic [3:0]  pe_e, pe_o;

  uart_word_rx #(.PARITY_ODD(1'b0), .GAP_LIMIT(16)) u_even (
    .clk(clk), .rst(rst), .rx(rx_e), .dat_out(dat_e), .rx_done(done_e),
    .parity_error(pe_e), .framing_error(fe_e), .busy(busy_e)
  );

  uart_word_rx #(.PARITY_ODD(1'b1), .GAP_LIMIT(16)) u_odd (
    .clk(clk), .rst(rst), .rx(rx_o), .dat_out(dat_o), .rx_done(done_o),
    .parity_error(pe_o), .framing_error(fe_o), .busy(busy_o)
  );

  typedef struct {
    logic [31:0] word;
    logic [3:0]  flip;
    int          gap;
    logic [31:0] exp_dat;
    logic [3:0]  exp_perr;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic [3:0]  perr;
  } exp_t;

  exp_t q_e[$];
  exp_t q_o[$];
  vec_t vecs[6];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  fe_cnt_e = 0, fe_cnt_o = 0;
  int  done_cnt_e = 0, done_cnt_o = 0;
  int  done_cyc_e = 0;
  bit  use_odd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard side: pop expectations as words complete, count error pulses.
  task automatic sample();
    exp_t x;
    if (done_e) begin
      done_cnt_e++;
      done_cyc_e = cyc;
      $display("even rx_done cyc=%0d dat_out=%h parity_error=%b", cyc, dat_e, pe_e);
      if (q_e.size() == 0) begin
        check("even_unexpected_rx_done", 32'd1, 32'd0);
      end else begin
        x = q_e.pop_front();
        check("even_dat_out", dat_e, x.dat);
        check("even_parity_error", {28'd0, pe_e}, {28'd0, x.perr});
      end
    end
    if (done_o) begin
      done_cnt_o++;
      $display("odd rx_done cyc=%0d dat_out=%h parity_error=%b", cyc, dat_o, pe_o);
      if (q_o.size() == 0) begin
        check("odd_unexpected_rx_done", 32'd1, 32'd0);
      end else begin
        x = q_o.pop_front();
        check("odd_dat_out", dat_o, x.dat);
        check("odd_parity_error", {28'd0, pe_o}, {28'd0, x.perr});
      end
    end
    if (fe_e) fe_cnt_e++;
    if (fe_o) fe_cnt_o++;
    if (done_e || fe_e) check("even_done_fe_exclusive", {31'd0, done_e & fe_e}, 32'd0);
    if (done_o || fe_o) check("odd_done_fe_exclusive", {31'd0, done_o & fe_o}, 32'd0);
  endtask

  // Drive one serial bit to the active receiver, then sample after the edge.
  task automatic tick(input logic b);
    if (use_odd) begin
      rx_o = b;
      rx_e = 1'b1;
    end else begin
      rx_e = b;
      rx_o = 1'b1;
    end
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic flip, input logic stop_bit);
    logic p;
    p = (^d) ^ use_odd ^ flip;
    tick(1'b0);
    for (int i = 0; i < 8; i++) tick(d[i]);
    tick(p);
    tick(stop_bit);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [3:0] flip, input int gap,
                           input logic [31:0] exp_dat, input logic [3:0] exp_perr);
    exp_t x;
    x.dat  = exp_dat;
    x.perr = exp_perr;
    if (use_odd) q_o.push_back(x);
    else         q_e.push_back(x);
    for (int b = 0; b < 4; b++) begin
      send_byte(w[8*b +: 8], flip[b], 1'b1);
      if (b < 3) repeat (gap) tick(1'b1);
    end
  endtask

  initial begin
    int st;
    int fe0;
    int d0;
    logic [31:0] w;

    vecs[0] = '{32'hDEADBEEF, 4'b0000, 0,  32'hDEADBEEF, 4'b0000};
    vecs[1] = '{32'h12345678, 4'b0100, 0,  32'h12345678, 4'b0100};
    vecs[2] = '{32'h00000000, 4'b1111, 0,  32'h00000000, 4'b1111};
    vecs[3] = '{32'hFFFFFFFF, 4'b1001, 3,  32'hFFFFFFFF, 4'b1001};
    vecs[4] = '{32'h13579BDF, 4'b0000, 15, 32'h13579BDF, 4'b0000};
    vecs[5] = '{32'hA5C3E1F0, 4'b0010, 1,  32'hA5C3E1F0, 4'b0010};

    rst  = 1'b1;
    rx_e = 1'b1;
    rx_o = 1'b1;
    @(negedge clk);
    repeat (3) tick(1'b1);
    check("reset_dat_out", dat_e, 32'd0);
    check("reset_parity_error", {28'd0, pe_e}, 32'd0);
    check("reset_rx_done", {31'd0, done_e}, 32'd0);
    check("reset_framing_error", {31'd0, fe_e}, 32'd0);
    check("reset_busy_even", {31'd0, busy_e}, 32'd0);
    check("reset_busy_odd", {31'd0, busy_o}, 32'd0);
    rst = 1'b0;

    // Back-to-back DEADBEEF; rx_done must be seen after the 44th sampled bit.
    tick(1'b1);
    st = cyc + 1;
    d0 = done_cnt_e;
    send_word(32'hDEADBEEF, 4'b0000, 0, 32'hDEADBEEF, 4'b0000);
    repeat (3) tick(1'b1);
    check("latency_done_count", done_cnt_e - d0, 32'd1);
    check("latency_cycles", done_cyc_e - st, 32'd43);
    check("latency_busy_after", {31'd0, busy_e}, 32'd0);
    check("latency_queue_drained", q_e.size(), 32'd0);

    // Table of words sent back to back, with various parity flips and gaps.
    for (int i = 0; i < 6; i++) begin
      send_word(vecs[i].word, vecs[i].flip, vecs[i].gap, vecs[i].exp_dat, vecs[i].exp_perr);
    end
    repeat (3) tick(1'b1);
    check("table_queue_drained", q_e.size(), 32'd0);

    // Bad stop bit on byte 1, line held low, then a clean word.
    fe0 = fe_cnt_e;
    send_byte(8'h3C, 1'b0, 1'b1);
    send_byte(8'hC3, 1'b0, 1'b0);
    check("stop_framing_pulse", fe_cnt_e - fe0, 32'd1);
    check("stop_busy_cleared", {31'd0, busy_e}, 32'd0);
    check("stop_dat_out_held", dat_e, vecs[5].exp_dat);
    check("stop_parity_error_held", {28'd0, pe_e}, {28'd0, vecs[5].exp_perr});
    repeat (5) tick(1'b0);
    tick(1'b1);
    send_word(32'hA5A5A5A5, 4'b0000, 0, 32'hA5A5A5A5, 4'b0000);
    repeat (3) tick(1'b1);
    check("stop_single_framing", fe_cnt_e - fe0, 32'd1);
    check("stop_queue_drained", q_e.size(), 32'd0);

    // Two bytes then an idle line: timeout on the 16th idle sample.
    fe0 = fe_cnt_e;
    send_byte(8'h11, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0, 1'b1);
    repeat (15) tick(1'b1);
    check("gap15_no_framing", fe_cnt_e - fe0, 32'd0);
    check("gap15_busy", {31'd0, busy_e}, 32'd1);
    tick(1'b1);
    check("gap16_framing", fe_cnt_e - fe0, 32'd1);
    check("gap16_busy_cleared", {31'd0, busy_e}, 32'd0);
    repeat (2) tick(1'b1);
    check("gap_no_rx_done", q_e.size(), 32'd0);

    // Reset during byte 2 data bits, then a word starting on the first free clock.
    fe0 = fe_cnt_e;
    d0  = done_cnt_e;
    send_byte(8'h44, 1'b0, 1'b1);
    send_byte(8'h33, 1'b0, 1'b1);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    rst = 1'b1;
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    check("rst_mid_dat_out", dat_e, 32'd0);
    check("rst_mid_busy", {31'd0, busy_e}, 32'd0);
    check("rst_mid_no_pulses", (fe_cnt_e - fe0) + (done_cnt_e - d0), 32'd0);
    rst = 1'b0;
    send_word(32'h00FF00FF, 4'b0000, 0, 32'h00FF00FF, 4'b0000);
    repeat (3) tick(1'b1);
    check("rst_word_done", done_cnt_e - d0, 32'd1);
    check("rst_no_framing", fe_cnt_e - fe0, 32'd0);
    check("rst_queue_drained", q_e.size(), 32'd0);

    // Random words through the odd-parity instance.
    use_odd = 1'b1;
    d0 = done_cnt_o;
    for (int n = 0; n < 500; n++) begin
      w = $urandom;
      send_word(w, 4'b0000, int'($urandom_range(0, 3)), w, 4'b0000);
    end
    repeat (3) tick(1'b1);
    check("odd_random_done_count", done_cnt_o - d0, 32'd500);
    check("odd_queue_drained", q_o.size(), 32'd0);
    check("odd_no_framing", fe_cnt_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
